shift_add_multiplier: RTL
=========================

// Module: shift_add_multiplier
// PURPOSE
//   Sequential unsigned WIDTH x WIDTH multiplier built around the team's ripple-carry adder.
//   Forms one partial product per cycle with a WIDTH-bit add and a right shift.
//   Consumes the adder's WIDTH+1-bit sum, carry included, as its accumulate step.
//   Sits downstream of operand registers; hands a 2*WIDTH-bit product to the next stage with a start/done handshake.
// PARAMETERS
//   WIDTH   4   operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
// PORTS
//   clk      in   1        single clock, rising-edge
//   rst      in   1        asynchronous, active-high reset
//   start    in   1        request a multiply; sampled only when ready=1
//   a        in   WIDTH    multiplicand, unsigned; captured on the accepting edge
//   b        in   WIDTH    multiplier, unsigned; captured on the accepting edge
//   ready    out  1        block can accept start (state IDLE or DONE)
//   busy     out  1        multiply in progress (state RUN)
//   done     out  1        one-cycle pulse: product valid and newly updated
//   product  out  2*WIDTH  last completed result; held until the next completion
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers=0.
//   States:
//     IDLE -> RUN on start.
//     RUN -> RUN while cnt != 0.
//     RUN -> DONE when the last step completes.
//     DONE -> RUN on start; DONE -> IDLE otherwise.
//   Accept edge (ready & start):
//     M <= a, HI <= 0, LO <= b, cnt <= WIDTH-1.
//     Next state RUN.
//   Each RUN edge:
//     {c,S} = LO[0] ? HI + M : {1'b0,HI}. The sum is WIDTH+1 bits from the adder, carry not dropped.
//     {HI,LO} <= {c,S,LO} >> 1.
//     If cnt == 0: product <= the shifted {HI,LO} value, next state DONE. Else cnt <= cnt-1.
//   Latency: start accepted at edge k; product and done valid after edge k+WIDTH.
//     done high for exactly one cycle.
//     Back-to-back start while in DONE gives throughput of one result per WIDTH+1 cycles.
//   start while busy=1: ignored; the in-flight operation and operands are unaffected.
//   a/b may change freely after the accept edge.
//   product changes only on the completion edge or on reset. It is never partially updated while busy.
//   Overflow impossible: (2^W-1)^2 < 2^(2W).
//   Reset mid-RUN aborts the operation. No done is produced and product returns to 0.
//   Outputs are registered or decoded directly from the state register, with no combinational path from start to the outputs.
// STRUCTURE
//   Shared package: state encoding localparams (ST_IDLE, ST_RUN, ST_DONE), 2-bit state type, default WIDTH.
//   One sub-module: the team's ripple-carry adder (FourBitAdder for WIDTH=4; a WIDTH-generic ripple adder otherwise).
//   It is instantiated once for HI+M, with the 5-bit/WIDTH+1 sum used as-is.
//   Top level holds the FSM, the cnt register (clog2(WIDTH) bits), the M/HI/LO registers and the product register.
// TESTING
//   1. Reset then a=0,b=0,start one cycle -> done after 4 edges, product=8'h00; ready=1 during reset.
//   2. a=15,b=15 -> product=8'hE1 (225), the carry path is exercised; a=1,b=15 -> 8'h0F; a=15,b=1 -> 8'h0F.
//   3. a=13,b=11 -> product=8'h8F (143); busy=1 for exactly 4 cycles, done=1 for exactly 1 cycle.
//   4. Hold start high continuously with a=3,b=5 then a=7,b=9:
//      product=8'h0F then 8'h3F, done every 5 cycles, with no lost or duplicated results.
//   5. a=6,b=7 start, then start=1 with a=2,b=2 while busy -> second request ignored, product=8'h2A.
//   6. a=9,b=9 start, assert rst 2 cycles later (asynchronously, mid-cycle):
//      outputs reset immediately, no done pulse, product=0.
//      Next a=2,b=3 -> product=8'h06.
//   Exhaustive sweep: all 256 a/b pairs compared against a*b; WIDTH=8 smoke test: 255*255 -> 16'hFE01.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and default operand width.
package shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder, WIDTH-bit operands, WIDTH+1-bit sum with the carry-out as MSB.
// Purely combinational; no handshake.
module shift_add_multiplier_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ carry[i];
        assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign sum[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one add-and-shift step per cycle.
// Latency WIDTH cycles from the accepting edge to done; one result per WIDTH+1 cycles back-to-back.
// start is honoured only while ready; requests while busy are dropped.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   step_sum;

    shift_add_multiplier_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x   (hi_reg),
        .y   (m_reg),
        .sum (add_sum)
    );

    // Carry of the accumulate is kept: it becomes the MSB shifted into HI.
    assign step_sum = lo_reg[0] ? add_sum : {1'b0, hi_reg};

    assign ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            m_reg   <= '0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        m_reg  <= a;
                        hi_reg <= '0;
                        lo_reg <= b;
                        cnt    <= CNT_W'(WIDTH - 1);
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    hi_reg <= step_sum[WIDTH:1];
                    lo_reg <= {step_sum[0], lo_reg[WIDTH-1:1]};
                    if (cnt == '0) begin
                        product <= {step_sum, lo_reg[WIDTH-1:1]};
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
